// File: rtl/rgb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_led_seq_ctrl
//
// Pattern sequencer for the two on-board RGB LEDs (LED4 and LED5). The display
// mode comes from the slide switches, colour phases advance on an internal step
// tick, and every lit channel is dimmed by one shared free-running PWM. All
// logic runs on the board clock; the step tick and PWM are enables, not clocks.
//
// Parameters
//   TICK_DIV : clock cycles per pattern step (must be >= 2)
//   PWM_BITS : width of the free-running PWM counter
//   DUTY     : on-cycles per PWM period, 0 .. 2**PWM_BITS
//              (0 keeps every LED dark, 2**PWM_BITS keeps lit channels on)
//
// Ports
//   clk      in   1  board clock, rising edge
//   rst      in   1  synchronous active-high reset
//   sw       in   2  mode select from slide switches (asynchronous to clk)
//                      00 OFF, 01 CYCLE, 10 ALT, 11 WHITE
//   led4_r/g/b  out  LED4 colour channels (1 = lit)
//   led5_r/g/b  out  LED5 colour channels (1 = lit)
//   step     out  1  one-cycle pulse on every pattern step
//   phase    out  2  current colour phase: 0 = R, 1 = G, 2 = B
// -----------------------------------------------------------------------------
module rgb_led_seq_ctrl #(
    parameter int TICK_DIV = 125_000_000,
    parameter int PWM_BITS = 8,
    parameter int DUTY     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic       led4_r,
    output logic       led4_g,
    output logic       led4_b,
    output logic       led5_r,
    output logic       led5_g,
    output logic       led5_b,
    output logic       step,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_CYCLE = 2'b01,
        MODE_ALT   = 2'b10,
        MODE_WHITE = 2'b11
    } mode_t;

    localparam int                  TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int                  TICK_MAX  = TICK_DIV - 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_MAX[TICK_W-1:0];
    // One extra bit so that DUTY = 2**PWM_BITS compares above every counter value.
    localparam logic [PWM_BITS:0]   DUTY_CMP  = DUTY[PWM_BITS:0];

    logic [1:0]          r_swMeta;
    logic [1:0]          r_swSync;
    mode_t               r_mode;
    logic [TICK_W-1:0]   r_tickCnt;
    logic [PWM_BITS-1:0] r_pwmCnt;
    logic [1:0]          r_phase;
    logic                r_step;
    logic [2:0]          r_led4;
    logic [2:0]          r_led5;

    mode_t               w_swMode;
    logic                w_modeChange;
    logic                w_tickWrap;
    logic                w_pwmOn;
    logic [1:0]          w_phaseNext;
    logic [2:0]          w_led4Colour;
    logic [2:0]          w_led5Colour;

    // Map a colour phase to an {r,g,b} one-hot; phase 3 never occurs and stays dark.
    function automatic logic [2:0] colourOf(input logic [1:0] p);
        case (p)
            2'd0:    colourOf = 3'b100;
            2'd1:    colourOf = 3'b010;
            2'd2:    colourOf = 3'b001;
            default: colourOf = 3'b000;
        endcase
    endfunction

    // Next phase in the R -> G -> B -> R rotation.
    function automatic logic [1:0] rotate3(input logic [1:0] p);
        rotate3 = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Two-flop synchroniser for the slide switches; the mode register behind it
    // makes a switch change visible to the pattern logic three edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_swMeta <= 2'b00;
            r_swSync <= 2'b00;
        end else begin
            r_swMeta <= sw;
            r_swSync <= r_swMeta;
        end
    end

    // Free-running PWM counter shared by all six channels; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwmCnt <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + 1'b1;
        end
    end

    // Combinational decode: mode change detect, step condition, PWM gate,
    // next phase for the current mode and the colour each LED should show.
    always_comb begin
        w_swMode     = mode_t'(r_swSync);
        w_modeChange = (w_swMode != r_mode);
        w_tickWrap   = (r_tickCnt == TICK_LAST);
        w_pwmOn      = ({1'b0, r_pwmCnt} < DUTY_CMP);

        w_phaseNext  = 2'd0;
        w_led4Colour = 3'b000;
        w_led5Colour = 3'b000;
        case (r_mode)
            MODE_CYCLE: begin
                w_phaseNext  = rotate3(r_phase);
                w_led4Colour = colourOf(r_phase);
                w_led5Colour = colourOf(rotate3(r_phase));
            end
            MODE_ALT: begin
                w_phaseNext  = {1'b0, ~r_phase[0]};
                w_led4Colour = r_phase[0] ? 3'b000 : 3'b100;
                w_led5Colour = r_phase[0] ? 3'b100 : 3'b000;
            end
            MODE_WHITE: begin
                w_phaseNext  = 2'd0;
                w_led4Colour = 3'b111;
                w_led5Colour = 3'b111;
            end
            default: begin
                w_phaseNext  = 2'd0;
                w_led4Colour = 3'b000;
                w_led5Colour = 3'b000;
            end
        endcase
    end

    // Mode FSM with registered outputs. A mode change restarts the pattern
    // (phase and tick counter to 0) and suppresses any step due on that edge;
    // OFF keeps the tick counter parked so no step ever fires. LED outputs
    // are gated by PWM and lag phase/pwm counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= MODE_OFF;
            r_tickCnt <= '0;
            r_phase   <= 2'd0;
            r_step    <= 1'b0;
            r_led4    <= 3'b000;
            r_led5    <= 3'b000;
        end else begin
            r_mode <= w_swMode;
            r_led4 <= w_led4Colour & {3{w_pwmOn}};
            r_led5 <= w_led5Colour & {3{w_pwmOn}};
            if (w_modeChange || (r_mode == MODE_OFF)) begin
                r_tickCnt <= '0;
                r_phase   <= 2'd0;
                r_step    <= 1'b0;
            end else if (w_tickWrap) begin
                r_tickCnt <= '0;
                r_phase   <= w_phaseNext;
                r_step    <= 1'b1;
            end else begin
                r_tickCnt <= r_tickCnt + 1'b1;
                r_step    <= 1'b0;
            end
        end
    end

    assign led4_r = r_led4[2];
    assign led4_g = r_led4[1];
    assign led4_b = r_led4[0];
    assign led5_r = r_led5[2];
    assign led5_g = r_led5[1];
    assign led5_b = r_led5[0];
    assign step   = r_step;
    assign phase  = r_phase;

endmodule
